// File: rtl/main_memory.sv
// Word-addressed main memory with fixed access latency and stats.
// Ports: clk/rst, req_* request in, resp_* response out, report/stat_*.
module main_memory #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  input  logic        report,
  output logic        stat_valid,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef logic [31:0] mem_t [DEPTH];

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [15:0] SAT = 16'hFFFF;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = 32'(i);
    end
    return m;
  endfunction

  // Power-up image only; reset never touches the array.
  mem_t mem = init_mem();

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        stat_valid_q, stat_valid_d;
  logic [15:0] stat_reads_q, stat_reads_d;
  logic [15:0] stat_writes_q, stat_writes_d;

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign stat_valid  = stat_valid_q;
  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;

  always_comb begin
    resp_rdata = '0;
    if (state_q == RESP && !wr_q) begin
      resp_rdata = mem[addr_q];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    // Snapshot uses pre-edge counts, so a
    // completing response is not included.
    stat_valid_d  = report;
    stat_reads_d  = report ? rd_cnt_q : '0;
    stat_writes_d = report ? wr_cnt_q : '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (wr_q) begin
          if (wr_cnt_q != SAT) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
          end
        end else if (rd_cnt_q != SAT) begin
          rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      stat_valid_q  <= 1'b0;
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      stat_valid_q  <= stat_valid_d;
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  // Commit on the edge that ends RESP; a reset
  // on that edge aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && wr_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory (LATENCY=4 and LATENCY=1 builds).
// Stimulus process predicts; negedge monitor compares.
module tb_main_memory;
  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        report = 1'b0;
  logic        req_ready, resp_valid, stat_valid;
  logic [31:0] resp_rdata;
  logic [15:0] stat_reads, stat_writes;

  logic        req_ready1, resp_valid1, stat_valid1;
  logic [31:0] resp_rdata1;
  logic [15:0] stat_reads1, stat_writes1;

  main_memory #(.LATENCY(L), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .report(report), .stat_valid(stat_valid),
    .stat_reads(stat_reads), .stat_writes(stat_writes)
  );

  main_memory #(.LATENCY(1), .DEPTH(256)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(1'b1), .req_ready(req_ready1),
    .req_write(1'b0), .req_addr(8'h05),
    .req_wdata(32'h0),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
    .report(1'b0), .stat_valid(stat_valid1),
    .stat_reads(stat_reads1), .stat_writes(stat_writes1)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          due;
  } req_t;

  typedef struct {
    int rd;
    int wc;
    int due;
  } st_t;

  req_t        q[$];
  st_t         sq[$];
  logic [31:0] mem_m [256];
  int          reads_m = 0;
  int          writes_m = 0;
  int          last_pop_cyc = -10;
  bit          last_pop_wr = 0;
  int          rst_edge_cyc = -10;
  bit          prev_rv1 = 0;
  bit          mon_en = 0;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  bit d_valid = 0, d_ready = 0;
  bit d_rep = 0, d_rst = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cyc %0d)",
                  name, act, exp, cyc);
  endtask

  // One cycle: account for the edge just taken,
  // then drive this cycle's inputs.
  task automatic step(input bit v, input bit w,
                      input logic [7:0] a,
                      input logic [31:0] d,
                      input bit rep, input bit r);
    int rc, wc;
    bit rr;
    @(posedge clk);
    #1;
    if (d_rst) begin
      q.delete();
      sq.delete();
      reads_m = 0;
      writes_m = 0;
      last_pop_cyc = -10;
      rst_edge_cyc = cyc;
    end else begin
      if (d_rep) begin
        rc = reads_m;
        wc = writes_m;
        if (last_pop_cyc == cyc - 1) begin
          if (last_pop_wr) wc--;
          else rc--;
        end
        sq.push_back('{rc, wc, cyc});
      end
      if (d_valid && d_ready)
        q.push_back('{req_write, req_addr,
                      req_wdata, cyc + L - 1});
    end
    rr = r;
    if (rr && q.size() != 0 && q[0].due == cyc)
      rr = 0;
    rst = rr;
    req_valid = v;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    report = rep;
    d_valid = v;
    d_ready = req_ready;
    d_rep = rep;
    d_rst = rr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 1'($urandom), 8'($urandom),
           $urandom, 0, 0);
  endtask

  task automatic req(input bit w,
                     input logic [7:0] a,
                     input logic [31:0] d);
    int n = 0;
    do begin
      step(1, w, a, d, 0, 0);
      n++;
    end while (!d_ready && n < 50);
    if (!d_ready) chk("req_accept_timeout", 0, 1);
    idle(1);
  endtask

  always @(negedge clk) begin
    req_t e;
    st_t s;
    logic [31:0] exp;
    if (mon_en) begin
      chk("req_ready", req_ready, 32'(q.size() == 0));
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_resp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("resp_cycle", cyc, e.due);
          exp = e.wr ? 32'h0 : mem_m[e.addr];
          chk("resp_rdata", resp_rdata, exp);
          if (e.wr) begin
            mem_m[e.addr] = e.wdata;
            if (writes_m < 65535) writes_m++;
          end else if (reads_m < 65535) begin
            reads_m++;
          end
          last_pop_cyc = cyc;
          last_pop_wr = e.wr;
        end
      end else begin
        chk("idle_rdata", resp_rdata, 0);
        if (q.size() != 0 && q[0].due < cyc) begin
          chk("resp_timeout", 0, 1);
          void'(q.pop_front());
        end
      end
      if (sq.size() != 0 && sq[0].due == cyc) begin
        s = sq.pop_front();
        chk("stat_valid", stat_valid, 1);
        chk("stat_reads", stat_reads, s.rd);
        chk("stat_writes", stat_writes, s.wc);
      end else if (stat_valid) begin
        chk("spurious_stat", 1, 0);
      end
      if (cyc != rst_edge_cyc)
        chk("l1_toggle", resp_valid1, !prev_rv1);
      chk("l1_ready", req_ready1, !resp_valid1);
      if (resp_valid1)
        chk("l1_rdata", resp_rdata1, 32'h5);
    end
    prev_rv1 = resp_valid1;
  end

  initial begin
    for (int i = 0; i < 256; i++)
      mem_m[i] = 32'(i);
    step(0, 0, 0, 0, 0, 0);
    mon_en = 1;
    chk("reset_stat", stat_reads, 0);
    idle(2);
    req(0, 8'h20, 0);
    idle(6);
    req(1, 8'h28, 32'h00abcdef);
    req(0, 8'h28, 0);
    req(0, 8'h30, 0);
    idle(6);
    req(1, 8'h18, 32'hdeadbeef);
    step(0, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    req(0, 8'h18, 0);
    idle(6);
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    req(0, 8'h01, 0);
    req(1, 8'h02, 32'h12345678);
    req(0, 8'h02, 0);
    req(1, 8'h03, 32'hcafef00d);
    req(0, 8'h04, 0);
    idle(6);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom), 1'($urandom),
           8'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 299) == 0));
    idle(10);
    chk("drain_resp", q.size(), 0);
    chk("drain_stat", sq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to response (legal range 1..15).
REQ-002 Parameter DEPTH, default 256, number of 32-bit words; word-addressed by req_addr.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  upstream (L2 cache miss/write-through path) presents a request.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  8  word address.
REQ-009 req_wdata  input  32  write data.
REQ-010 resp_valid  output  1  one-cycle pulse marking request completion (reads and writes).
REQ-011 resp_rdata  output  32  read data, valid only with resp_valid on a read.
REQ-012 report  input  1  statistics snapshot request.
REQ-013 stat_valid  output  1  one-cycle pulse with snapshot.
REQ-014 stat_reads  output  16  snapshot of completed read count.
REQ-015 stat_writes  output  16  snapshot of completed write count.

Function
REQ-016 FSM states IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance: req_valid && req_ready at edge T; req_write, req_addr, req_wdata latched at T; later changes on req_* ignored until the next acceptance.
REQ-018 IDLE -> BUSY on acceptance; latency counter loaded with LATENCY-1; BUSY decrements each cycle.
REQ-019 BUSY -> RESP when counter reaches 0; for LATENCY=1 acceptance goes directly to RESP.
REQ-020 resp_valid SHALL be 1 exactly in the cycle LATENCY cycles after acceptance, for one cycle; RESP -> IDLE unconditionally next edge.
REQ-021 Back-to-back: req_ready returns to 1 the cycle after resp_valid; peak throughput one request per LATENCY+1 cycles.
REQ-022 Read: resp_rdata = mem[latched addr] value at the time of response; resp_rdata holds 0 when resp_valid is 0.
REQ-023 Write: mem[latched addr] <= latched wdata on the edge ending the RESP cycle; resp_rdata = 0 for writes.
REQ-024 Memory initial contents (elaboration time): mem[i] = i zero-extended to 32 bits; contents SHALL NOT be altered by rst.
REQ-025 Read counter increments on each read response, write counter on each write response; both saturate at 16'hFFFF.
REQ-026 report high at edge T: stat_valid = 1 in cycle T+1 with counter values as of edge T (excluding a response completing at T); report held high produces one snapshot per cycle.
REQ-027 report is independent of FSM state and SHALL NOT stall or alter requests.
REQ-028 req_valid while not ready: no effect, no error; upstream must hold request until accepted.

Reset
REQ-029 rst at any edge forces state IDLE, counter 0, req_ready 1 in the following cycle, resp_valid 0, resp_rdata 0, stat_valid 0, stat outputs 0, both counters 0.
REQ-030 rst asserted in BUSY or RESP aborts the transaction: no resp_valid, no memory write committed.
REQ-031 req_valid coincident with rst is not accepted.
REQ-032 Memory array is not cleared by rst (REQ-024).

Verification
REQ-033 After reset, read addr 8'h20, LATENCY=4 -> resp_valid exactly 4 cycles after acceptance, resp_rdata 32'h00000020, req_ready low for 4 cycles.
REQ-034 Write 32'h00abcdef to 8'h28, then read 8'h28 -> second response returns 32'h00abcdef; addr 8'h30 still returns 32'h00000030.
REQ-035 Change req_addr/req_wdata during BUSY -> response and memory reflect latched values only.
REQ-036 Assert rst two cycles into a write to 8'h18 -> no resp_valid; subsequent read of 8'h18 returns 32'h00000018; counters read 0.
REQ-037 Three reads and two writes then report pulse -> stat_valid one cycle later, stat_reads 3, stat_writes 2.
REQ-038 LATENCY=1 build: continuous req_valid -> resp_valid every 2nd cycle, req_ready alternating 1/0.
